fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment (FND) digit-scan controller.
- Cycles through NUM_DIGITS common lines, driving one at a time with a one-hot common-select whose polarity is set by a parameter.
- Presents the selected digit's 4-bit value to the downstream segment decoder.
- Inserts a programmable all-off gap between digits to suppress ghosting, and supports per-digit blanking and a frame-complete pulse.
- Sits between the counter/datapath and the board FND pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be at least 2.
- SEL_W, $clog2(NUM_DIGITS), width of the digit index; derived, do not override.
- REFRESH_DIV, 100000, clock cycles each digit stays driven (1 ms at 100 MHz); must be at least 1.
- GAP_CYCLES, 8, clock cycles all commons are off between digits; must be at least 1.
- COM_ACTIVE_LOW, 1, 1 = selected common driven 0 and others 1; 0 = inverted polarity.

Ports:
- i_clk, in, 1, system clock.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_en, in, 1, scan enable; 0 = display off.
- i_data, in, 4*NUM_DIGITS, digit values; digit k = i_data[4k+3:4k].
- i_blank_mask, in, NUM_DIGITS, 1 = digit k stays dark during its slot.
- o_digit_sel, out, NUM_DIGITS, common-select lines, one-hot or all-inactive.
- o_digit_val, out, 4, value of the currently driven digit.
- o_digit_idx, out, SEL_W, index of the current or next digit.
- o_frame, out, 1, single-cycle pulse when the last digit's slot ends.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n; all state is cleared immediately when i_reset_n=0.
- Reset values:
  - state = S_IDLE.
  - o_digit_sel = all inactive (all 1s when COM_ACTIVE_LOW=1).
  - o_digit_val = 0, o_digit_idx = 0, o_frame = 0.
  - Internal counters = 0.
- State S_IDLE:
  - Commons all inactive, idx held at 0.
  - i_en=1 sampled -> S_GAP, gap_cnt <= 0.
- State S_GAP:
  - Commons all inactive; gap_cnt increments each cycle.
  - At gap_cnt == GAP_CYCLES-1: o_digit_val <= i_data slice at idx (snapshot), div_cnt <= 0, -> S_DRIVE.
  - S_GAP therefore lasts exactly GAP_CYCLES cycles.
- State S_DRIVE:
  - Common[idx] active unless i_blank_mask[idx]=1, in which case all commons are inactive.
  - i_blank_mask is sampled live, not snapshotted.
  - div_cnt increments each cycle; at div_cnt == REFRESH_DIV-1:
    - idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1, wrapping with no out-of-range index ever produced.
    - -> S_GAP, gap_cnt <= 0.
    - o_frame <= 1 for one cycle if idx was NUM_DIGITS-1.
- Data snapshot:
  - o_digit_val is stable for the whole S_DRIVE slot.
  - Changes to i_data mid-slot take effect in the next slot of that digit.
- Commons output: o_digit_sel is a combinational decode of the registered (state, idx, mask); no other inputs feed it.
- Latency:
  - i_en rises at edge 0 -> first common active in the cycle after edge GAP_CYCLES.
  - Full frame = NUM_DIGITS*(GAP_CYCLES+REFRESH_DIV) cycles.
- i_en deassert: i_en=0 in any state -> next edge S_IDLE, idx <= 0, o_frame <= 0, commons off. There is no partial-slot completion.
- Simultaneous events:
  - i_en=0 at the same edge as slot end: disable wins and o_frame is not pulsed.
  - Reset asserted mid-operation: immediate return to reset values, regardless of clock.
- Index and counter widths:
  - o_digit_idx is valid in all states; in S_GAP it shows the digit about to be driven.
  - Counter widths are $clog2 of the respective parameter (minimum 1 bit); no overflow is possible by construction.

Decomposition:
- Package fnd_pkg holds:
  - State encoding localparams: S_IDLE=2'd0, S_GAP=2'd1, S_DRIVE=2'd2.
  - The 4-bit digit value width constant.
- Sub-module fnd_com_decoder (parameters NUM_DIGITS, COM_ACTIVE_LOW):
  - Inputs: idx, enable. Output: one-hot select of the configured polarity.
  - When enable=0, the output is all inactive.
  - It is the generalised N-way successor of the team's fixed 2-to-4 active-low select decoder.
- The top level holds the FSM, counters and data mux.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2, COM_ACTIVE_LOW=1, with i_data=16'h4321 unless stated.
1. Reset then i_en=1:
   - o_digit_sel = 4'b1111 for 2 cycles.
   - Then 4'b1110 with o_digit_val=1 for 4 cycles.
   - Then 2 gap cycles, then 4'b1101 with o_digit_val=2, and so on.
2. Run 2 full frames:
   - idx sequence 0,1,2,3,0 with no out-of-range index.
   - o_frame high exactly 1 cycle after each digit-3 slot; frame period 24 cycles.
3. i_blank_mask=4'b0100:
   - Digit-2 slot keeps o_digit_sel=4'b1111.
   - Timing unchanged, o_digit_val=3 still presented.
4. Change i_data to 16'h9876 in the 2nd cycle of the digit-0 slot:
   - o_digit_val stays 1 for that slot.
   - Digit 1 shows 7; the next digit-0 slot shows 6.
5. Drop i_en during the digit-2 slot:
   - Next cycle o_digit_sel=4'b1111, o_digit_idx=0, no o_frame.
   - Re-enable restarts at digit 0 after 2 gap cycles.
6. Assert i_reset_n=0 asynchronously mid-slot (between clock edges):
   - Outputs go to reset values immediately.
   - Repeat scenario 1 with COM_ACTIVE_LOW=0: selects are inverted (4'b0001 for digit 0) and idle state is 4'b0000.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND digit-scan controller.
// Holds the state encoding, the digit value width and a counter-width helper.
package fnd_pkg;

  typedef logic [1:0] fnd_state_t;

  localparam fnd_state_t S_IDLE  = 2'd0;
  localparam fnd_state_t S_GAP   = 2'd1;
  localparam fnd_state_t S_DRIVE = 2'd2;

  localparam int DIGIT_W = 4;

  // A counter that must reach n-1 needs $clog2(n) bits; never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnd_com_decoder.sv
// N-way one-hot common-select decoder with configurable output polarity.
// When enable is low every common is driven to its inactive level.
module fnd_com_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEL_W          = $clog2(NUM_DIGITS),
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic [SEL_W-1:0]      idx,
  input  logic                  enable,
  output logic [NUM_DIGITS-1:0] sel
);

  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      onehot[k] = enable && (idx == SEL_W'(k));
    end
  end

  assign sel = COM_ACTIVE_LOW ? ~onehot : onehot;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed seven-segment digit-scan controller: walks the commons one at a
// time with an all-off gap between digits, snapshotting each digit's value.
//
// state   | meaning
// S_IDLE  | display off, index parked at 0, waiting for i_en
// S_GAP   | all commons off for GAP_CYCLES, index shows the next digit
// S_DRIVE | common[idx] active (unless blanked) for REFRESH_DIV cycles
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEL_W          = $clog2(NUM_DIGITS),
  parameter int REFRESH_DIV    = 100000,
  parameter int GAP_CYCLES     = 8,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_en,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]         i_blank_mask,
  output logic [NUM_DIGITS-1:0]         o_digit_sel,
  output logic [DIGIT_W-1:0]            o_digit_val,
  output logic [SEL_W-1:0]              o_digit_idx,
  output logic                          o_frame
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int DIV_W = cnt_width(REFRESH_DIV);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

  fnd_state_t            state;
  fnd_state_t            state_nxt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [SEL_W-1:0]      idx;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [DIGIT_W-1:0]    digit_arr [NUM_DIGITS];
  logic                  gap_done;
  logic                  slot_done;
  logic                  com_en;

  assign gap_done  = (state == S_GAP)   && (gap_cnt == GAP_LAST);
  assign slot_done = (state == S_DRIVE) && (div_cnt == DIV_LAST);

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_arr[k] = i_data[k*DIGIT_W +: DIGIT_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!i_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_GAP;
        S_GAP:   if (gap_done)  state_nxt = S_DRIVE;
        S_DRIVE: if (slot_done) state_nxt = S_GAP;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The blank mask is re-registered every cycle so the commons decode only
  // from flops, yet a mask change still applies within the current slot.
  always_comb begin
    com_en = (state == S_DRIVE) && !mask_q[idx];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      gap_cnt     <= '0;
      div_cnt     <= '0;
      idx         <= '0;
      mask_q      <= '0;
      o_digit_val <= '0;
      o_frame     <= 1'b0;
    end else begin
      o_frame <= 1'b0;
      mask_q  <= i_blank_mask;
      if (!i_en) begin
        idx     <= '0;
        gap_cnt <= '0;
        div_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            gap_cnt <= '0;
          end
          S_GAP: begin
            if (gap_done) begin
              o_digit_val <= digit_arr[idx];
              div_cnt     <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          S_DRIVE: begin
            if (slot_done) begin
              idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
              gap_cnt <= '0;
              o_frame <= (idx == IDX_LAST);
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: begin
            idx <= '0;
          end
        endcase
      end
    end
  end

  assign o_digit_idx = idx;

  fnd_com_decoder #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SEL_W          (SEL_W),
    .COM_ACTIVE_LOW (COM_ACTIVE_LOW)
  ) u_com_decoder (
    .idx    (idx),
    .enable (com_en),
    .sel    (o_digit_sel)
  );

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: a time-position model predicts every output each
// cycle, and directed literal checks pin the model at key points.
module tb_fnd_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 2;
  localparam int SLOT  = G + R;
  localparam int FRAME = N * SLOT;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic [3:0]  mask;

  logic [3:0] sel, sel_hi;
  logic [3:0] val, val_hi;
  logic [1:0] idx, idx_hi;
  logic       frame, frame_hi;

  int n_pass  = 0;
  int n_total = 0;
  int c       = 0;

  fnd_scan_ctrl #(
    .NUM_DIGITS (N), .REFRESH_DIV (R), .GAP_CYCLES (G), .COM_ACTIVE_LOW (1'b1)
  ) u_dut (
    .i_clk (clk), .i_reset_n (rst_n), .i_en (en), .i_data (data),
    .i_blank_mask (mask), .o_digit_sel (sel), .o_digit_val (val),
    .o_digit_idx (idx), .o_frame (frame)
  );

  fnd_scan_ctrl #(
    .NUM_DIGITS (N), .REFRESH_DIV (R), .GAP_CYCLES (G), .COM_ACTIVE_LOW (1'b0)
  ) u_dut_hi (
    .i_clk (clk), .i_reset_n (rst_n), .i_en (en), .i_data (data),
    .i_blank_mask (mask), .o_digit_sel (sel_hi), .o_digit_val (val_hi),
    .o_digit_idx (idx_hi), .o_frame (frame_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: m_p is the number of edges since the scan was enabled.
  logic       m_run;
  int         m_p;
  logic [3:0] m_val;
  logic [3:0] m_mask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_p    <= 0;
      m_val  <= 4'h0;
      m_mask <= 4'h0;
    end else begin
      m_mask <= mask;
      if (!en) begin
        m_run <= 1'b0;
        m_p   <= 0;
      end else if (!m_run) begin
        m_run <= 1'b1;
        m_p   <= 0;
      end else begin
        m_p <= m_p + 1;
        if ((m_p + 1) % SLOT == G)
          m_val <= 4'(data >> (4 * (((m_p + 1) / SLOT) % N)));
      end
    end
  end

  always @(negedge clk) begin
    int         d;
    logic       drive;
    logic [3:0] exp_sel;
    logic [3:0] exp_sel_hi;
    logic [1:0] exp_idx;
    logic       exp_frame;
    d         = (m_p / SLOT) % N;
    drive     = m_run && ((m_p % SLOT) >= G);
    exp_sel   = 4'b1111;
    if (drive && !m_mask[d]) exp_sel[d] = 1'b0;
    exp_sel_hi = ~exp_sel;
    exp_idx   = m_run ? 2'(d) : 2'd0;
    exp_frame = m_run && (m_p > 0) && (m_p % FRAME == 0);
    check("model_sel",    32'(sel),      32'(exp_sel));
    check("model_sel_hi", 32'(sel_hi),   32'(exp_sel_hi));
    check("model_val",    32'(val),      32'(m_val));
    check("model_val_hi", 32'(val_hi),   32'(m_val));
    check("model_idx",    32'(idx),      32'(exp_idx));
    check("model_idx_hi", 32'(idx_hi),   32'(exp_idx));
    check("model_frame",  32'(frame),    32'(exp_frame));
    check("model_frame_hi", 32'(frame_hi), 32'(exp_frame));
  end

  task automatic go_to(input int target);
    while (c < target) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},    32'(sel),    32'h0000000f);
    check({tag, "_sel_hi"}, 32'(sel_hi), 32'h0);
    check({tag, "_val"},    32'(val),    32'h0);
    check({tag, "_idx"},    32'(idx),    32'h0);
    check({tag, "_frame"},  32'(frame),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    data  = 16'h4321;
    mask  = 4'b0000;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_sel", 32'(sel), 32'hf);

    // Basic scan, frame pulse, mid-slot data change, blanking
    en = 1'b1; c = 0;
    go_to(1);  check("s1_gap0_sel", 32'(sel), 32'hf);  check("s1_gap0_idx", 32'(idx), 32'd0);
    go_to(2);  check("s1_gap1_sel", 32'(sel), 32'hf);
    go_to(3);  check("s1_d0_sel", 32'(sel), 32'he);    check("s1_d0_val", 32'(val), 32'd1);
               check("s1_d0_sel_hi", 32'(sel_hi), 32'h1);
    go_to(6);  check("s1_d0_end_sel", 32'(sel), 32'he);
    go_to(7);  check("s1_gap_d1_sel", 32'(sel), 32'hf); check("s1_gap_d1_idx", 32'(idx), 32'd1);
    go_to(9);  check("s1_d1_sel", 32'(sel), 32'hd);    check("s1_d1_val", 32'(val), 32'd2);
    go_to(15); check("s1_d2_sel", 32'(sel), 32'hb);    check("s1_d2_val", 32'(val), 32'd3);
    go_to(21); check("s1_d3_sel", 32'(sel), 32'h7);    check("s1_d3_val", 32'(val), 32'd4);
    go_to(24); check("s2_frame_pre", 32'(frame), 32'd0);
    go_to(25); check("s2_frame1", 32'(frame), 32'd1);  check("s2_wrap_idx", 32'(idx), 32'd0);
    go_to(26); check("s2_frame_post", 32'(frame), 32'd0);
    go_to(49); check("s2_frame2", 32'(frame), 32'd1);
    go_to(52); data = 16'h9876;
    go_to(53); check("s4_d0_hold", 32'(val), 32'd1);
    go_to(57); check("s4_d1_new", 32'(val), 32'd7);
    go_to(63); check("s4_d2_new", 32'(val), 32'd8);
    go_to(75); check("s4_d0_next", 32'(val), 32'd6);   check("s4_d0_sel", 32'(sel), 32'he);
    data = 16'h4321;
    mask = 4'b0100;
    go_to(87); check("s3_blank_sel", 32'(sel), 32'hf); check("s3_blank_val", 32'(val), 32'd3);
               check("s3_blank_idx", 32'(idx), 32'd2); check("s3_blank_sel_hi", 32'(sel_hi), 32'h0);
    go_to(90); check("s3_blank_end_sel", 32'(sel), 32'hf);
    go_to(91); mask = 4'b0000;
    go_to(93); check("s3_d3_sel", 32'(sel), 32'h7);

    // Disable mid-slot on digit 2
    go_to(112); check("s5_d2_sel", 32'(sel), 32'hb);
    en = 1'b0;
    go_to(113); check("s5_off_sel", 32'(sel), 32'hf); check("s5_off_idx", 32'(idx), 32'd0);
                check("s5_off_frame", 32'(frame), 32'd0);
    go_to(115); check("s5_idle_sel", 32'(sel), 32'hf);
    en = 1'b1; c = 0;
    go_to(2);  check("s5_re_gap_sel", 32'(sel), 32'hf);
    go_to(3);  check("s5_re_d0_sel", 32'(sel), 32'he); check("s5_re_d0_val", 32'(val), 32'd1);

    // Disable coinciding with the end of the last digit's slot
    go_to(24); check("sim_d3_sel", 32'(sel), 32'h7);
    en = 1'b0;
    go_to(25); check("sim_no_frame", 32'(frame), 32'd0); check("sim_sel", 32'(sel), 32'hf);
               check("sim_idx", 32'(idx), 32'd0);

    // Asynchronous reset between clock edges
    en = 1'b1; c = 0;
    go_to(4);  check("s6_pre_sel", 32'(sel), 32'he);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("s6_async");
    @(negedge clk);
    rst_n = 1'b1; c = 0;
    go_to(2);  check("s6_gap_sel_hi", 32'(sel_hi), 32'h0);
    go_to(3);  check("s6_d0_sel_hi", 32'(sel_hi), 32'h1); check("s6_d0_sel", 32'(sel), 32'he);
               check("s6_d0_val", 32'(val), 32'd1);
    go_to(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
